// File: rtl/dds_pkg.sv
// Shared defaults and state encoding for the DDS keying front-end.
package dds_pkg;

    localparam int OOK_FIFO_DEPTH = 8;
    localparam int OOK_PERIOD_W   = 16;

    typedef enum logic {
        OOK_IDLE = 1'b0,
        OOK_SEND = 1'b1
    } ook_state_e;

endpackage

// File: rtl/ook_byte_fifo.sv
// Byte FIFO with fall-through read data; full/empty come from the registered occupancy.
module ook_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign data    = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ook_symbol_gen.sv
// OOK keying generator: drains the byte FIFO MSB first, holding each bit for a
// per-byte latched number of clocks, with no gap between queued bytes.
module ook_symbol_gen
    import dds_pkg::*;
#(
    parameter int FIFO_DEPTH = OOK_FIFO_DEPTH,
    parameter int PERIOD_W   = OOK_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    input  logic [PERIOD_W-1:0] sym_period,
    output logic                ook_data,
    output logic                full,
    output logic                empty,
    output logic                busy,
    output logic                byte_done,
    output logic                overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ook_state_e          state;
    ook_state_e          state_next;
    logic [7:0]          shreg;
    logic [7:0]          fifo_data;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] sym_cnt;
    logic [2:0]          bit_cnt;
    logic [CW-1:0]       fifo_count;
    logic                pop;
    logic                load;
    logic                shift;
    logic                bit_end;
    logic                avail;
    logic                ook_next;
    logic                done_next;

    ook_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en & ~rst),
        .pop   (pop),
        .wdata (wr_data),
        .data  (fifo_data),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign avail   = (fifo_count != '0);
    assign bit_end = (sym_cnt == period - PERIOD_W'(1));
    assign busy    = (state == OOK_SEND);

    always_ff @(posedge clk) begin
        if (rst) state <= OOK_IDLE;
        else     state <= state_next;
    end

    // ook_next is the value of the bit that will be on air next cycle, so the
    // output flop stays aligned with the shift register after load or shift.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        done_next  = 1'b0;
        ook_next   = 1'b0;
        case (state)
            OOK_IDLE: begin
                if (avail) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    ook_next   = fifo_data[7];
                    state_next = OOK_SEND;
                end
            end
            OOK_SEND: begin
                ook_next = shreg[7];
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        done_next = 1'b1;
                        if (avail) begin
                            pop      = 1'b1;
                            load     = 1'b1;
                            ook_next = fifo_data[7];
                        end else begin
                            shift      = 1'b1;
                            ook_next   = 1'b0;
                            state_next = OOK_IDLE;
                        end
                    end else begin
                        shift    = 1'b1;
                        ook_next = shreg[6];
                    end
                end
            end
            default: state_next = OOK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            period    <= '0;
            sym_cnt   <= '0;
            bit_cnt   <= '0;
            ook_data  <= 1'b0;
            byte_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ook_data  <= ook_next;
            byte_done <= done_next;
            overflow  <= wr_en & full;
            if (load) begin
                shreg   <= fifo_data;
                period  <= (sym_period == '0) ? PERIOD_W'(1) : sym_period;
                sym_cnt <= '0;
                bit_cnt <= '0;
            end else if (shift) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
                sym_cnt <= '0;
            end else if (state == OOK_SEND) begin
                sym_cnt <= sym_cnt + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ook_symbol_gen.sv
// Directed bench for ook_symbol_gen: timing, back-to-back, full/overflow,
// zero/changed period and reset abort, with hand-derived expectations.
module tb_ook_symbol_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [15:0] sym_period;
    logic        ook_data;
    logic        full;
    logic        empty;
    logic        busy;
    logic        byte_done;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ook_symbol_gen #(
        .FIFO_DEPTH (8),
        .PERIOD_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .sym_period (sym_period),
        .ook_data   (ook_data),
        .full       (full),
        .empty      (empty),
        .busy       (busy),
        .byte_done  (byte_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // One clock: outputs of the new cycle are sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] pat_b;
        logic [7:0] q [9];
        int         t0;
        int         s;
        int         dn_cnt;
        logic       e;

        // Reset, with writes presented during reset that must be ignored
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h3C; sym_period = 16'd4;
        step(); step();
        chk("rst_ook", ook_data, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", byte_done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        rst = 1'b0; wr_en = 1'b0;
        step();
        chk("rst_wr_ignored_empty", empty, 1'b1);
        chk("rst_wr_ignored_ook", ook_data, 1'b0);
        step();

        // Single byte 0xA5, period 4: bit 7 appears two cycles after the write
        sym_period = 16'd4; pat = 8'hA5;
        wr_en = 1'b1; wr_data = pat;
        step(); wr_en = 1'b0;
        chk("a5_n1_empty", empty, 1'b0);
        chk("a5_n1_ook", ook_data, 1'b0);
        chk("a5_n1_busy", busy, 1'b0);
        step();
        for (int i = 0; i < 32; i++) begin
            chk("a5_bit", ook_data, pat[7 - i/4]);
            if (i % 4 == 0) chk("a5_nodone", byte_done, 1'b0);
            step();
        end
        chk("a5_done", byte_done, 1'b1);
        chk("a5_tail_ook", ook_data, 1'b0);
        chk("a5_tail_busy", busy, 1'b0);
        step();
        chk("a5_done_clr", byte_done, 1'b0);
        chk("a5_idle_ook", ook_data, 1'b0);
        chk("a5_idle_empty", empty, 1'b1);

        // Back-to-back 0xFF, 0x00 at period 1: no gap, two byte_done pulses
        sym_period = 16'd1;
        wr_en = 1'b1; wr_data = 8'hFF;
        step(); wr_data = 8'h00;
        step(); wr_en = 1'b0;
        dn_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            chk("b2b_ook", ook_data, (i < 8));
            chk("b2b_done", byte_done, (i == 8 || i == 16));
            if (byte_done) dn_cnt++;
            step();
        end
        chk("b2b_done_cnt", (dn_cnt == 2), 1'b1);
        chk("b2b_idle", busy, 1'b0);

        // Nine writes at period 100: one popped, eight buffered, tenth overflows
        sym_period = 16'd100;
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        t0 = 0;
        for (int k = 0; k < 9; k++) begin
            wr_en = 1'b1; wr_data = q[k];
            if (k == 0) t0 = cyc + 2;
            step();
        end
        chk("ovf_full", full, 1'b1);
        chk("ovf_pre", overflow, 1'b0);
        wr_data = 8'hEE;
        step(); wr_en = 1'b0;
        chk("ovf_pulse", overflow, 1'b1);
        chk("ovf_still_full", full, 1'b1);
        step();
        chk("ovf_clr", overflow, 1'b0);
        for (int j = 0; j < 72; j++) begin
            s = t0 + 100 * j;
            e = q[j/8][7 - (j % 8)];
            if (cyc <= s) begin
                wait_until(s);
                chk("fifo_bit_start", ook_data, e);
                if (j % 8 == 0) chk("fifo_byte_done", byte_done, 1'b1);
            end
            wait_until(s + 99);
            chk("fifo_bit_end", ook_data, e);
        end
        wait_until(t0 + 7200);
        chk("fifo_last_done", byte_done, 1'b1);
        chk("fifo_tail_ook", ook_data, 1'b0);
        chk("fifo_tail_busy", busy, 1'b0);
        chk("fifo_drained", empty, 1'b1);
        step();

        // Period 0 acts as period 1
        sym_period = 16'd0;
        wr_en = 1'b1; wr_data = 8'h80;
        step(); wr_en = 1'b0;
        chk("p0_n1_ook", ook_data, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("p0_bit", ook_data, (i == 0));
            chk("p0_busy", busy, 1'b1);
            step();
        end
        chk("p0_done", byte_done, 1'b1);
        chk("p0_tail", ook_data, 1'b0);
        step();

        // Period 2 -> 5 mid-byte: current byte keeps 2, next byte latches 5
        sym_period = 16'd2; pat = 8'hC3; pat_b = 8'h3C;
        wr_en = 1'b1; wr_data = pat;
        step(); wr_data = pat_b;
        step(); wr_en = 1'b0;
        for (int c = 0; c < 56; c++) begin
            e = (c < 16) ? pat[7 - c/2] : pat_b[7 - (c - 16)/5];
            chk("chg_bit", ook_data, e);
            if (c == 16) chk("chg_done_a", byte_done, 1'b1);
            if (c == 3) sym_period = 16'd5;
            step();
        end
        chk("chg_done_b", byte_done, 1'b1);
        chk("chg_tail", ook_data, 1'b0);
        step();

        // Reset during bit index 3 with three bytes queued
        sym_period = 16'd3;
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_data = 8'hFF;
            if (k == 0) t0 = cyc + 2;
            step();
        end
        wr_en = 1'b0;
        wait_until(t0 + 10);
        chk("abort_pre_ook", ook_data, 1'b1);
        chk("abort_pre_busy", busy, 1'b1);
        chk("abort_pre_empty", empty, 1'b0);
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("abort_ook", ook_data, 1'b0);
        chk("abort_empty", empty, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", byte_done, 1'b0);
        chk("abort_full", full, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step();
            chk("abort_quiet_done", byte_done, 1'b0);
            chk("abort_quiet_ook", ook_data, 1'b0);
        end
        wr_en = 1'b1; wr_data = 8'h81;
        step(); wr_en = 1'b0;
        chk("restart_n1_ook", ook_data, 1'b0);
        step();
        chk("restart_n2_ook", ook_data, 1'b1);
        chk("restart_n2_busy", busy, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
